// File: rtl/tensorcore_dispatch.sv
// rtl/tensorcore_dispatch.sv - tensor-core command dispatcher: queue pop, MU/LSU issue, response, in-flight tracking
// Optional feature macro: TENSORCORE_DISPATCH_FENCE_EN (adds the FENCE wait state)
module tensorcore_dispatch #(
   parameter int DATA_WIDTH      = 96,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  q_empty_i,
   input  logic [DATA_WIDTH-1:0] q_data_i,
   output logic                  q_pop_o,
   output logic [DATA_WIDTH-1:0] issue_data_o,
   output logic                  mu_valid_o,
   input  logic                  mu_ready_i,
   output logic                  lsu_valid_o,
   input  logic                  lsu_ready_i,
   input  logic                  mu_done_i,
   input  logic                  lsu_done_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [1:0]            resp_data_o,
   output logic [CNT_W-1:0]      outstanding_o,
   output logic                  busy_o
);

   // The instruction word sits in the top 32 bits; its opcode is the low 7 bits of that word.
   localparam int OP_LSB = DATA_WIDTH - 32;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [1:0] RESP_OK      = 2'b00;
   localparam logic [1:0] RESP_ILLEGAL = 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
`ifdef TENSORCORE_DISPATCH_FENCE_EN
      , FENCE
`endif
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             unit_mu;
   logic [1:0]       resp_code;
   logic             issue_fire;
   logic [6:0]       opcode;
   logic             is_lsu, is_mu, is_fence, is_legal;
   logic [CNT_W:0]   cnt_sum;
   logic [1:0]       done_cnt;

   // Decode the head-of-queue opcode (only meaningful while the queue is non-empty).
   always_comb begin
      opcode   = q_data_i[OP_LSB +: 7];
      is_lsu   = (opcode == 7'b0000111) || (opcode == 7'b0100111);
      is_mu    = (opcode == 7'b1010111);
`ifdef TENSORCORE_DISPATCH_FENCE_EN
      is_fence = (opcode == 7'b0001111);
`else
      is_fence = 1'b0;
`endif
      is_legal = is_lsu || is_mu || is_fence;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // Next-state and handshake outputs; the pop is gated by reset_n so nothing is consumed while reset is held.
   always_comb begin
      next_state   = state;
      q_pop_o      = 1'b0;
      mu_valid_o   = 1'b0;
      lsu_valid_o  = 1'b0;
      resp_valid_o = 1'b0;
      issue_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (reset_n && !q_empty_i && (cnt < MAX_CNT)) begin
               q_pop_o = 1'b1;
               if (is_lsu || is_mu) next_state = ISSUE;
`ifdef TENSORCORE_DISPATCH_FENCE_EN
               else if (is_fence)   next_state = FENCE;
`endif
               else                 next_state = RESP;
            end
         end
         ISSUE: begin
            mu_valid_o  = unit_mu;
            lsu_valid_o = !unit_mu;
            if (unit_mu ? mu_ready_i : lsu_ready_i) begin
               issue_fire = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) next_state = IDLE;
         end
`ifdef TENSORCORE_DISPATCH_FENCE_EN
         FENCE: begin
            if (cnt == '0) next_state = RESP;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // Latch the popped command, its target unit and its response code; held until the next pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         issue_data_o <= '0;
         unit_mu      <= 1'b0;
         resp_code    <= RESP_OK;
      end else if (q_pop_o) begin
         issue_data_o <= q_data_i;
         unit_mu      <= is_mu;
         resp_code    <= is_legal ? RESP_OK : RESP_ILLEGAL;
      end
   end

   // In-flight count: +1 per issue handshake, -1 per done pulse, floored at zero.
   always_comb begin
      cnt_sum  = {1'b0, cnt} + {{CNT_W{1'b0}}, issue_fire};
      done_cnt = {1'b0, mu_done_i} + {1'b0, lsu_done_i};
      if (cnt_sum > (CNT_W+1)'(done_cnt)) cnt_next = CNT_W'(cnt_sum - (CNT_W+1)'(done_cnt));
      else                                cnt_next = '0;
   end

   // Counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt_next;
   end

   assign outstanding_o = cnt;
   assign resp_data_o   = resp_code;
   assign busy_o        = (state != IDLE) || (cnt != '0);

endmodule

// File: tb/tb_tensorcore_dispatch.sv
// tb/tb_tensorcore_dispatch.sv - directed self-checking bench for tensorcore_dispatch
module tb_tensorcore_dispatch;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        q_empty_i;
   logic [95:0] q_data_i;
   logic        q_pop_o;
   logic [95:0] issue_data_o;
   logic        mu_valid_o, mu_ready_i;
   logic        lsu_valid_o, lsu_ready_i;
   logic        mu_done_i, lsu_done_i;
   logic        resp_valid_o, resp_ready_i;
   logic [1:0]  resp_data_o;
   logic [2:0]  outstanding_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tensorcore_dispatch dut (
      .clk(clk), .reset_n(reset_n), .q_empty_i(q_empty_i), .q_data_i(q_data_i), .q_pop_o(q_pop_o),
      .issue_data_o(issue_data_o), .mu_valid_o(mu_valid_o), .mu_ready_i(mu_ready_i),
      .lsu_valid_o(lsu_valid_o), .lsu_ready_i(lsu_ready_i), .mu_done_i(mu_done_i), .lsu_done_i(lsu_done_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
      .outstanding_o(outstanding_o), .busy_o(busy_o)
   );

   function automatic logic [95:0] mk_cmd(input logic [6:0] op, input logic [31:0] tag);
      return {tag[24:0], op, tag ^ 32'h5A5A_1234, ~tag};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Runs one command start to finish with ready inputs assumed high; no checks.
   task automatic run_cmd(input logic [95:0] c);
      q_data_i = c; q_empty_i = 1'b0;
      tick();
      q_empty_i = 1'b1;
      tick();
      tick();
   endtask

   task automatic drain(input int n, input bit use_mu);
      repeat (n) begin
         if (use_mu) mu_done_i = 1'b1; else lsu_done_i = 1'b1;
         tick();
         mu_done_i = 1'b0; lsu_done_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; q_empty_i = 1'b0; q_data_i = mk_cmd(7'b1010111, 32'h1);
      mu_ready_i = 1'b1; lsu_ready_i = 1'b1; resp_ready_i = 1'b1; mu_done_i = 1'b0; lsu_done_i = 1'b0;
      sample(); sample();
      checks++; if (q_pop_o !== 1'b0) begin errors++; $display("FAIL rst_pop got=%b exp=0", q_pop_o); end
      checks++; if ({mu_valid_o, lsu_valid_o, resp_valid_o, busy_o} !== 4'b0) begin errors++; $display("FAIL rst_valids got=%b exp=0000", {mu_valid_o, lsu_valid_o, resp_valid_o, busy_o}); end
      checks++; if (issue_data_o !== 96'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", issue_data_o); end
      checks++; if ({resp_data_o, outstanding_o} !== 5'b0) begin errors++; $display("FAIL rst_resp_cnt got=%b exp=00000", {resp_data_o, outstanding_o}); end
      q_empty_i = 1'b1;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_mu();
      logic [95:0] c;
      c = mk_cmd(7'b1010111, 32'hC0DE_0001);
      q_data_i = c; q_empty_i = 1'b0;
      sample();
      checks++; if (q_pop_o !== 1'b1) begin errors++; $display("FAIL mu_pop got=%b exp=1", q_pop_o); end
      tick(); q_empty_i = 1'b1;
      sample();
      checks++; if ({mu_valid_o, lsu_valid_o} !== 2'b10) begin errors++; $display("FAIL mu_valid got=%b exp=10", {mu_valid_o, lsu_valid_o}); end
      checks++; if (issue_data_o !== c) begin errors++; $display("FAIL mu_data got=%h exp=%h", issue_data_o, c); end
      tick();
      sample();
      checks++; if ({resp_valid_o, resp_data_o} !== 3'b100) begin errors++; $display("FAIL mu_resp got=%b exp=100", {resp_valid_o, resp_data_o}); end
      checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL mu_cnt got=%0d exp=1", outstanding_o); end
      tick();
      sample();
      checks++; if ({resp_valid_o, busy_o} !== 2'b01) begin errors++; $display("FAIL mu_after got=%b exp=01", {resp_valid_o, busy_o}); end
      drain(1, 1'b1);
      sample();
      checks++; if ({outstanding_o, busy_o} !== 4'b0000) begin errors++; $display("FAIL mu_drain got=%b exp=0000", {outstanding_o, busy_o}); end
      tick();
   endtask

   task automatic test_lsu_limit();
      logic [95:0] c;
      for (int k = 0; k < 4; k++) begin
         c = mk_cmd((k % 2) ? 7'b0100111 : 7'b0000111, 32'h100 + k);
         q_data_i = c; q_empty_i = 1'b0;
         sample();
         checks++; if (q_pop_o !== 1'b1) begin errors++; $display("FAIL lsu_pop%0d got=%b exp=1", k, q_pop_o); end
         tick(); q_empty_i = 1'b1;
         sample();
         checks++; if ({lsu_valid_o, mu_valid_o, issue_data_o} !== {2'b10, c}) begin errors++; $display("FAIL lsu_issue%0d got=%b/%h exp=10/%h", k, {lsu_valid_o, mu_valid_o}, issue_data_o, c); end
         tick(); tick();
      end
      c = mk_cmd(7'b0000111, 32'h104);
      q_data_i = c; q_empty_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++; if ({q_pop_o, outstanding_o} !== {1'b0, 3'd4}) begin errors++; $display("FAIL lsu_full%0d got=%b/%0d exp=0/4", i, q_pop_o, outstanding_o); end
         tick();
      end
      lsu_done_i = 1'b1;
      sample();
      checks++; if (q_pop_o !== 1'b0) begin errors++; $display("FAIL lsu_done_cycle got=%b exp=0", q_pop_o); end
      tick(); lsu_done_i = 1'b0;
      sample();
      checks++; if ({q_pop_o, outstanding_o} !== {1'b1, 3'd3}) begin errors++; $display("FAIL lsu_fifth got=%b/%0d exp=1/3", q_pop_o, outstanding_o); end
      tick(); q_empty_i = 1'b1;
      tick(); tick();
      sample();
      checks++; if (outstanding_o !== 3'd4) begin errors++; $display("FAIL lsu_fifth_cnt got=%0d exp=4", outstanding_o); end
      tick();
      drain(4, 1'b0);
      sample();
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL lsu_drain got=%0d exp=0", outstanding_o); end
      tick();
   endtask

   task automatic test_illegal();
      q_data_i = mk_cmd(7'b1111111, 32'hBAD); q_empty_i = 1'b0;
      sample();
      checks++; if (q_pop_o !== 1'b1) begin errors++; $display("FAIL ill_pop got=%b exp=1", q_pop_o); end
      tick(); q_empty_i = 1'b1;
      sample();
      checks++; if ({mu_valid_o, lsu_valid_o, resp_valid_o, resp_data_o} !== 5'b00101) begin errors++; $display("FAIL ill_resp got=%b exp=00101", {mu_valid_o, lsu_valid_o, resp_valid_o, resp_data_o}); end
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL ill_cnt got=%0d exp=0", outstanding_o); end
      tick();
   endtask

   task automatic test_stall();
      logic [95:0] c;
      c = mk_cmd(7'b1010111, 32'h5757);
      mu_ready_i = 1'b0; resp_ready_i = 1'b0;
      q_data_i = c; q_empty_i = 1'b0;
      tick(); q_empty_i = 1'b1; q_data_i = ~c;
      for (int i = 0; i < 5; i++) begin
         sample();
         checks++; if ({mu_valid_o, issue_data_o} !== {1'b1, c}) begin errors++; $display("FAIL stall_issue%0d got=%b/%h exp=1/%h", i, mu_valid_o, issue_data_o, c); end
         tick();
      end
      mu_ready_i = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         sample();
         checks++; if ({resp_valid_o, resp_data_o} !== 3'b100) begin errors++; $display("FAIL stall_resp%0d got=%b exp=100", i, {resp_valid_o, resp_data_o}); end
         tick();
      end
      resp_ready_i = 1'b1;
      tick();
      sample();
      checks++; if ({resp_valid_o, outstanding_o} !== {1'b0, 3'd1}) begin errors++; $display("FAIL stall_end got=%b/%0d exp=0/1", resp_valid_o, outstanding_o); end
      tick();
      drain(1, 1'b1);
   endtask

   task automatic test_counter_concurrent();
      run_cmd(mk_cmd(7'b1010111, 32'h1));
      q_data_i = mk_cmd(7'b1010111, 32'h2); q_empty_i = 1'b0;
      tick(); q_empty_i = 1'b1;
      mu_done_i = 1'b1; lsu_done_i = 1'b1;
      sample();
      checks++; if ({mu_valid_o, outstanding_o} !== {1'b1, 3'd1}) begin errors++; $display("FAIL cc_pre got=%b/%0d exp=1/1", mu_valid_o, outstanding_o); end
      tick(); mu_done_i = 1'b0; lsu_done_i = 1'b0;
      sample();
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL cc_net got=%0d exp=0", outstanding_o); end
      mu_done_i = 1'b1;
      tick(); mu_done_i = 1'b0;
      sample();
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL cc_sat0 got=%0d exp=0", outstanding_o); end
      tick();
      run_cmd(mk_cmd(7'b0000111, 32'h3));
      mu_done_i = 1'b1; lsu_done_i = 1'b1;
      tick(); mu_done_i = 1'b0; lsu_done_i = 1'b0;
      sample();
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL cc_sat1 got=%0d exp=0", outstanding_o); end
      tick();
   endtask

   task automatic test_fence();
      run_cmd(mk_cmd(7'b1010111, 32'hF1));
      run_cmd(mk_cmd(7'b1010111, 32'hF2));
      q_data_i = mk_cmd(7'b0001111, 32'hFE); q_empty_i = 1'b0;
      sample();
      checks++; if ({q_pop_o, outstanding_o} !== {1'b1, 3'd2}) begin errors++; $display("FAIL fence_pop got=%b/%0d exp=1/2", q_pop_o, outstanding_o); end
      tick(); q_empty_i = 1'b1;
`ifdef TENSORCORE_DISPATCH_FENCE_EN
      sample();
      checks++; if ({resp_valid_o, busy_o} !== 2'b01) begin errors++; $display("FAIL fence_wait0 got=%b exp=01", {resp_valid_o, busy_o}); end
      tick();
      mu_done_i = 1'b1;
      tick(); mu_done_i = 1'b0;
      sample();
      checks++; if ({resp_valid_o, outstanding_o} !== {1'b0, 3'd1}) begin errors++; $display("FAIL fence_wait1 got=%b/%0d exp=0/1", resp_valid_o, outstanding_o); end
      tick();
      mu_done_i = 1'b1;
      tick(); mu_done_i = 1'b0;
      sample();
      checks++; if ({resp_valid_o, outstanding_o} !== {1'b0, 3'd0}) begin errors++; $display("FAIL fence_wait2 got=%b/%0d exp=0/0", resp_valid_o, outstanding_o); end
      tick();
      sample();
      checks++; if ({resp_valid_o, resp_data_o} !== 3'b100) begin errors++; $display("FAIL fence_resp got=%b exp=100", {resp_valid_o, resp_data_o}); end
      tick();
`else
      sample();
      checks++; if ({resp_valid_o, resp_data_o, outstanding_o} !== {3'b101, 3'd2}) begin errors++; $display("FAIL fence_illegal got=%b/%0d exp=101/2", {resp_valid_o, resp_data_o}, outstanding_o); end
      tick();
      drain(2, 1'b1);
`endif
      sample();
      checks++; if ({busy_o, outstanding_o} !== 4'b0000) begin errors++; $display("FAIL fence_end got=%b exp=0000", {busy_o, outstanding_o}); end
      tick();
   endtask

   task automatic test_reset_mid_issue();
      mu_ready_i = 1'b0;
      q_data_i = mk_cmd(7'b1010111, 32'hAB); q_empty_i = 1'b0;
      tick();
      q_data_i = mk_cmd(7'b0000111, 32'hCD);
      #2 reset_n = 1'b0;
      #1;
      checks++; if ({mu_valid_o, q_pop_o, busy_o, resp_valid_o} !== 4'b0) begin errors++; $display("FAIL rmid_outs got=%b exp=0000", {mu_valid_o, q_pop_o, busy_o, resp_valid_o}); end
      checks++; if (issue_data_o !== 96'h0) begin errors++; $display("FAIL rmid_data got=%h exp=0", issue_data_o); end
      tick();
      reset_n = 1'b1;
      sample();
      checks++; if (q_pop_o !== 1'b1) begin errors++; $display("FAIL rmid_pop got=%b exp=1", q_pop_o); end
      q_empty_i = 1'b1; mu_ready_i = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_single_mu();
      test_lsu_limit();
      test_illegal();
      test_stall();
      test_counter_concurrent();
      test_fence();
      test_reset_mid_issue();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tensorcore_dispatch.md
TENSORCORE_DISPATCH -- requirements
Module: tensorcore_dispatch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 96, meaning the width of a queued command {instruction[95:64], rs1[63:32], rs2[31:0]}.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of issued but not-yet-completed commands; CNT_W = $clog2(MAX_OUTSTANDING)+1.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 q_empty_i  input  1  command queue empty.
REQ-006 q_data_i  input  DATA_WIDTH  head-of-queue command; valid whenever q_empty_i=0 (show-ahead).
REQ-007 q_pop_o  output  1  one-cycle pulse that consumes the head command.
REQ-008 issue_data_o  output  DATA_WIDTH  latched command presented to the execution units.
REQ-009 mu_valid_o / mu_ready_i  output/input  1 each  matrix-unit issue handshake.
REQ-010 lsu_valid_o / lsu_ready_i  output/input  1 each  load/store-unit issue handshake.
REQ-011 mu_done_i, lsu_done_i  input  1 each  single-cycle completion pulses, one per issued command.
REQ-012 resp_valid_o / resp_ready_i  output/input  1 each  response handshake to the scalar core.
REQ-013 resp_data_o  output  2  response code: 2'b00 = OK, 2'b01 = illegal.
REQ-014 outstanding_o  output  CNT_W  current in-flight count.
REQ-015 busy_o  output  1  high when state != IDLE or outstanding_o != 0.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE and RESP, plus FENCE when the Configuration macro is defined.
REQ-017 Decode (opcode = instruction[6:0]): 7'b0000111 and 7'b0100111 go to the LSU; 7'b1010111 goes to the MU; 7'b0001111 is FENCE (REQ-030/031); any other opcode is illegal.
REQ-018 IDLE: when q_empty_i=0 and outstanding_o<MAX_OUTSTANDING, the block SHALL pulse q_pop_o and latch q_data_i into issue_data_o in the same cycle.
REQ-019 On that pop, the next state SHALL be ISSUE for LSU/MU commands and RESP with code 2'b01 for illegal commands; illegal commands are not issued.
REQ-020 IDLE with outstanding_o==MAX_OUTSTANDING SHALL NOT pop, even when the queue is non-empty.
REQ-021 ISSUE: exactly one of mu_valid_o/lsu_valid_o SHALL be asserted, with issue_data_o held stable until the matching ready is sampled high.
REQ-022 The issue handshake cycle SHALL increment the counter, and the next state SHALL be RESP with code 2'b00.
REQ-023 RESP: resp_valid_o and resp_data_o SHALL be held stable until resp_ready_i=1, then the FSM returns to IDLE; minimum occupancy per command is IDLE->ISSUE->RESP->IDLE, 3 cycles.
REQ-024 The counter SHALL update per cycle as: +1 on issue handshake, -1 per done pulse; simultaneous issue and two dones give a net -1.
REQ-025 A done pulse arriving with the counter at 0 SHALL be ignored, with the counter saturating at 0 (no wrap).
REQ-026 q_pop_o SHALL never be asserted while q_empty_i=1.
REQ-027 q_pop_o SHALL never be asserted outside IDLE.

Reset
REQ-028 While reset_n=0 the block SHALL hold: state IDLE; counter 0; q_pop_o, mu_valid_o, lsu_valid_o, resp_valid_o, busy_o 0; resp_data_o 2'b00; issue_data_o all zeros.
REQ-029 Reset asserted mid-ISSUE or mid-RESP SHALL abandon the command without a response; the first pop after deassertion occurs no earlier than the first rising edge with reset_n=1.

Configuration
REQ-030 With TENSORCORE_DISPATCH_FENCE_EN defined, a FENCE opcode SHALL be popped into state FENCE and wait until the counter is 0, then go to RESP with 2'b00; done pulses still decrement while waiting.
REQ-031 With TENSORCORE_DISPATCH_FENCE_EN undefined, a FENCE opcode SHALL be treated as illegal (RESP with 2'b01), and the FENCE state SHALL be absent.

Verification
REQ-032 Single MU command (opcode 7'b1010111), mu_ready_i tied 1, resp_ready_i tied 1 -> q_pop_o at cycle 0, mu_valid_o at cycle 1, resp 2'b00 at cycle 2, outstanding_o=1.
REQ-033 Five LSU commands, lsu_ready_i=1, no done pulses, MAX_OUTSTANDING=4 -> four issued; fifth not popped while outstanding_o=4; one lsu_done_i pulse -> fifth popped the next cycle.
REQ-034 Opcode 7'b1111111 -> popped, no valid to either unit, resp_data_o=2'b01, counter unchanged.
REQ-035 mu_ready_i low for 5 cycles during ISSUE, then resp_ready_i low for 3 cycles -> issue_data_o/mu_valid_o stable for 5 cycles, resp_valid_o/resp_data_o stable for 3 cycles.
REQ-036 Counter=1, issue handshake in the same cycle as mu_done_i and lsu_done_i -> counter=0; a further done at 0 -> counter stays 0.
REQ-037 With FENCE_EN defined: two outstanding MU commands, then FENCE -> response withheld until both mu_done_i pulses, then 2'b00; with FENCE_EN undefined -> immediate 2'b01.
